// File: rtl/melody_sequencer_if.sv
// Control/status bundle of the melody sequencer: the table write port,
// the transport controls and the sound/status outputs.
interface melody_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DIV_W  = 21,
  parameter int DUR_W  = 8
);
  logic              iWE;
  logic [ADDR_W-1:0] iWADDR;
  logic [DIV_W-1:0]  iWDIV;
  logic [DUR_W-1:0]  iWDUR;
  logic              iSTART;
  logic              iSTOP;
  logic              iLOOP;
  logic [DUR_W-1:0]  iGAP;
  logic              oSOUND;
  logic              oBUSY;
  logic              oDONE;
  logic [ADDR_W-1:0] oNOTE;

  // Host side: loads the table and drives the transport controls.
  modport master (
    output iWE, iWADDR, iWDIV, iWDUR, iSTART, iSTOP, iLOOP, iGAP,
    input  oSOUND, oBUSY, oDONE, oNOTE
  );

  // Sequencer side.
  modport slave (
    input  iWE, iWADDR, iWDIV, iWDUR, iSTART, iSTOP, iLOOP, iGAP,
    output oSOUND, oBUSY, oDONE, oNOTE
  );
endinterface

// File: rtl/melody_sequencer.sv
// Table-driven square-wave melody player. Each table entry holds a tone
// half-period (0 = rest) and a duration in ticks (0 = end of song). A
// prescaler turns the clock into duration ticks; an FSM walks the table,
// optionally inserting a silent gap after each note and looping the song.
module melody_sequencer #(
  parameter int TICK_DIV = 6_250_000,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int DIV_W    = 21,
  parameter int DUR_W    = 8
) (
  input  logic                iCLK,
  input  logic                iRST,
  melody_sequencer_if.slave   bus
);

  // The pointer carries one extra bit so that stepping past the last
  // entry is visible as a wrap (end of song) rather than aliasing to 0.
  localparam int PTR_W = ADDR_W + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q,   ptr_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [DUR_W-1:0]  cnt_q,   cnt_d;    // remaining note/gap ticks
  logic [PRE_W-1:0]  pre_q,   pre_d;    // tick prescaler
  logic [DIV_W-1:0]  tone_q,  tone_d;   // clocks into current half-period
  logic              sound_q, sound_d;
  logic              done_q,  done_d;

  logic [DIV_W-1:0]  div_mem [DEPTH];
  logic [DUR_W-1:0]  dur_mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr;
  logic [DIV_W-1:0]  rd_div;
  logic [DUR_W-1:0]  rd_dur;
  logic              tick;
  logic              eos;

  // Note table write port; out-of-range addresses are dropped.
  // NOTE: the table is plain storage with no reset so it maps onto RAM;
  // its contents survive iRST and are only defined once written.
  always_ff @(posedge iCLK) begin
    if (bus.iWE && ({1'b0, bus.iWADDR} < PTR_W'(DEPTH))) begin
      div_mem[bus.iWADDR] <= bus.iWDIV;
      dur_mem[bus.iWADDR] <= bus.iWDUR;
    end
  end

  // Table read for the FETCH state; a wrapped pointer reads entry 0 but
  // is flagged as end of song regardless of what that entry holds.
  always_comb begin
    rd_addr = '0;
    if (ptr_q < PTR_W'(DEPTH)) rd_addr = ptr_q[ADDR_W-1:0];
    rd_div = div_mem[rd_addr];
    rd_dur = dur_mem[rd_addr];
    eos    = (ptr_q >= PTR_W'(DEPTH)) || (rd_dur == '0);
    tick   = (pre_q == PRE_W'(TICK_DIV - 1));
  end

  // Sequencer next-state logic: table walk, tone generation, transport.
  // NOTE: every _d gets a default before the case so no path can leave a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    tone_d  = tone_q;
    sound_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        pre_d  = '0;
        tone_d = '0;
      end

      S_FETCH: begin
        div_d  = rd_div;
        cnt_d  = rd_dur;
        pre_d  = '0;
        tone_d = '0;
        if (eos) begin
          cnt_d = '0;
          ptr_d = '0;
          // An end marker at entry 0 is an empty song: never loop on it.
          if (bus.iLOOP && (ptr_q != '0)) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        sound_d = sound_q;
        if (div_q != '0) begin
          if (tone_q == div_q - DIV_W'(1)) begin
            tone_d  = '0;
            sound_d = ~sound_q;
          end else begin
            tone_d = tone_q + DIV_W'(1);
          end
        end
        if (tick) begin
          pre_d = '0;
          if (cnt_q == DUR_W'(1)) begin
            sound_d = 1'b0;
            tone_d  = '0;
            if (bus.iGAP == '0) begin
              ptr_d   = ptr_q + PTR_W'(1);
              cnt_d   = '0;
              state_d = S_FETCH;
            end else begin
              cnt_d   = bus.iGAP;
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      S_GAP: begin
        if (tick) begin
          pre_d = '0;
          if (cnt_q == DUR_W'(1)) begin
            ptr_d   = ptr_q + PTR_W'(1);
            cnt_d   = '0;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Start (re)launches the song from entry 0, abandoning any note.
    if (bus.iSTART) begin
      state_d = S_FETCH;
      ptr_d   = '0;
      cnt_d   = '0;
      pre_d   = '0;
      tone_d  = '0;
      sound_d = 1'b0;
      done_d  = 1'b0;
    end

    // Stop overrides everything, including a simultaneous start.
    if (bus.iSTOP) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      pre_d   = '0;
      tone_d  = '0;
      sound_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  // NOTE: non-blocking assignments make every register update from the
  // values of the previous cycle, independent of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      tone_q  <= '0;
      sound_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      tone_q  <= tone_d;
      sound_q <= sound_d;
      done_q  <= done_d;
    end
  end

  assign bus.oSOUND = sound_q;
  assign bus.oBUSY  = (state_q != S_IDLE);
  assign bus.oDONE  = done_q;
  assign bus.oNOTE  = ptr_q[ADDR_W-1:0];

endmodule
